// File: rtl/keypad_encoder_if.sv
// Keypad-side and calculator-side signals of the keypad encoder.
// The encoder connects through the master modport; the keypad/calculator model uses slave.
interface keypad_encoder_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [1:0] signal_out;
  logic [7:0] data_out;
  logic       key_pulse;

  modport master (
    input  row_in,
    output col_out,
    output signal_out,
    output data_out,
    output key_pulse
  );

  modport slave (
    output row_in,
    input  col_out,
    input  signal_out,
    input  data_out,
    input  key_pulse
  );
endinterface

// File: rtl/keypad_encoder.sv
// 4x4 matrix keypad scanner with press/release debounce, feeding a calculator
// with a decimal operand (data_out) and an operator code (signal_out).
module keypad_encoder #(
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 8
) (
  input  logic             clk,
  input  logic             rst,
  keypad_encoder_if.master kp
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);

  localparam logic [3:0] K_A    = 4'd10;
  localparam logic [3:0] K_B    = 4'd11;
  localparam logic [3:0] K_C    = 4'd12;
  localparam logic [3:0] K_STAR = 4'd13;
  localparam logic [3:0] K_HASH = 4'd14;
  localparam logic [3:0] K_D    = 4'd15;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } state_t;

  state_t            r_state;
  logic [3:0]        r_col_out;
  logic [SCAN_W-1:0] r_scan_cnt;
  logic [DEB_W-1:0]  r_deb_cnt;
  logic [1:0]        r_row_idx;
  logic [3:0]        r_key;
  logic [1:0]        r_signal;
  logic [7:0]        r_data;
  logic              r_key_pulse;
  logic              r_new_entry;

  logic [3:0]  w_row_low;
  logic [3:0]  w_row_first;
  logic        w_any_low;
  logic [1:0]  w_row_idx;
  logic [1:0]  w_col_idx;
  logic        w_row_high;
  logic [11:0] w_accum;
  logic        w_fits;
  logic [3:0]  w_col_next;

  // Lowest-numbered low row wins when several rows are pulled down together.
  assign w_row_low = ~kp.row_in;
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_row_prio
      if (gi == 0) begin : g_first
        assign w_row_first[gi] = w_row_low[gi];
      end else begin : g_rest
        assign w_row_first[gi] = w_row_low[gi] & ~(|w_row_low[gi-1:0]);
      end
    end
  endgenerate

  assign w_any_low  = |w_row_first;
  assign w_row_idx  = {w_row_first[3] | w_row_first[2], w_row_first[3] | w_row_first[1]};
  assign w_row_high = kp.row_in[r_row_idx];
  assign w_col_next = {r_col_out[2:0], r_col_out[3]};

  always_comb begin
    w_col_idx = 2'd0;
    case (r_col_out)
      4'b1110: w_col_idx = 2'd0;
      4'b1101: w_col_idx = 2'd1;
      4'b1011: w_col_idx = 2'd2;
      4'b0111: w_col_idx = 2'd3;
      default: w_col_idx = 2'd0;
    endcase
  end

  // Operand accumulate is done 12 bits wide so an overflowing digit can be detected and dropped.
  assign w_accum = ({4'd0, r_data} << 3) + ({4'd0, r_data} << 1) + {8'd0, r_key};
  assign w_fits  = (w_accum <= 12'd255);

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b0000: code = 4'd1;
      4'b0001: code = 4'd2;
      4'b0010: code = 4'd3;
      4'b0011: code = K_A;
      4'b0100: code = 4'd4;
      4'b0101: code = 4'd5;
      4'b0110: code = 4'd6;
      4'b0111: code = K_B;
      4'b1000: code = 4'd7;
      4'b1001: code = 4'd8;
      4'b1010: code = 4'd9;
      4'b1011: code = K_C;
      4'b1100: code = K_STAR;
      4'b1101: code = 4'd0;
      4'b1110: code = K_HASH;
      default: code = K_D;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] op_code(input logic [3:0] key);
    logic [1:0] code;
    case (key)
      K_A:     code = 2'b01;
      K_B:     code = 2'b10;
      K_C:     code = 2'b11;
      default: code = 2'b00;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SCAN;
      r_col_out   <= 4'b1110;
      r_scan_cnt  <= '0;
      r_deb_cnt   <= '0;
      r_row_idx   <= 2'd0;
      r_key       <= 4'd0;
      r_signal    <= 2'b00;
      r_data      <= 8'd0;
      r_key_pulse <= 1'b0;
      r_new_entry <= 1'b0;
    end else begin
      r_key_pulse <= 1'b0;
      case (r_state)
        SCAN: begin
          if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            if (w_any_low) begin
              r_state   <= DEB_PRESS;
              r_row_idx <= w_row_idx;
              r_key     <= key_code(w_row_idx, w_col_idx);
              r_deb_cnt <= '0;
            end else begin
              r_col_out <= w_col_next;
            end
          end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
          end
        end

        DEB_PRESS: begin
          if (!w_row_high) begin
            if (r_deb_cnt == DEB_LAST) begin
              r_state     <= HELD;
              r_deb_cnt   <= '0;
              r_key_pulse <= 1'b1;
              r_signal    <= op_code(r_key);
              // Key action lands on the same edge as the strobe.
              if (r_key <= 4'd9) begin
                if (r_new_entry) begin
                  r_data      <= {4'd0, r_key};
                  r_new_entry <= 1'b0;
                end else if (w_fits) begin
                  r_data <= w_accum[7:0];
                end
              end else if (r_key == K_A || r_key == K_B || r_key == K_C) begin
                r_new_entry <= 1'b1;
              end else if (r_key == K_STAR) begin
                r_data      <= 8'd0;
                r_new_entry <= 1'b0;
              end
            end else begin
              r_deb_cnt <= r_deb_cnt + 1'b1;
            end
          end else begin
            r_deb_cnt  <= '0;
            r_state    <= SCAN;
            r_col_out  <= w_col_next;
            r_scan_cnt <= '0;
          end
        end

        HELD: begin
          if (w_row_high) begin
            r_state   <= DEB_RELEASE;
            r_deb_cnt <= '0;
          end
        end

        DEB_RELEASE: begin
          if (w_row_high) begin
            if (r_deb_cnt == DEB_LAST) begin
              r_state    <= SCAN;
              r_deb_cnt  <= '0;
              r_signal   <= 2'b00;
              r_col_out  <= w_col_next;
              r_scan_cnt <= '0;
            end else begin
              r_deb_cnt <= r_deb_cnt + 1'b1;
            end
          end else begin
            r_deb_cnt <= '0;
            r_state   <= HELD;
          end
        end

        default: r_state <= SCAN;
      endcase
    end
  end

  assign kp.col_out    = r_col_out;
  assign kp.signal_out = r_signal;
  assign kp.data_out   = r_data;
  assign kp.key_pulse  = r_key_pulse;

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 Parameter SCAN_DIV, 16, clock cycles each column is driven before advancing.
REQ-002 Parameter DEBOUNCE, 8, consecutive stable samples required to accept a press or a release.
REQ-003 Port clk  input  1  single clock, all logic on rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port row_in  input  4  keypad rows, active-low, externally pulled up.
REQ-006 Port col_out  output  4  keypad column drive, one-hot active-low.
REQ-007 Port signal_out  output  2  operator code to the calculator: 00 idle, 01/10/11 while operator key held.
REQ-008 Port data_out  output  8  operand being entered, unsigned binary.
REQ-009 Port key_pulse  output  1  one-cycle strobe per accepted key press.

Function
REQ-010 Keymap (row,col): r0 = 1 2 3 A; r1 = 4 5 6 B; r2 = 7 8 9 C; r3 = * 0 # D.
REQ-011 A->01, B->10, C->11; * = clear entry; # and D accepted (key_pulse) with no other effect.
REQ-012 FSM states: SCAN, DEB_PRESS, HELD, DEB_RELEASE.
REQ-013 SCAN: col_out rotates 1110->1101->1011->0111->1110, advancing every SCAN_DIV cycles; row_in sampled on the last cycle of each column slot.
REQ-014 SCAN->DEB_PRESS when any row_in bit is 0; column frozen, key index latched; multiple rows low -> lowest row index wins.
REQ-015 DEB_PRESS: counter increments each cycle the latched row stays low; reaching DEBOUNCE -> HELD; latched row high before that -> counter cleared, back to SCAN, resume rotation at next column.
REQ-016 Entry to HELD: key_pulse high exactly one cycle; key action applied in the same cycle.
REQ-017 HELD: signal_out holds operator code for operator keys, else 00; latched row going high -> DEB_RELEASE.
REQ-018 DEB_RELEASE: DEBOUNCE consecutive high samples of latched row -> SCAN with signal_out = 00 that cycle; any low sample -> counter cleared, back to HELD, no new key_pulse.
REQ-019 signal_out therefore nonzero for at least DEBOUNCE+1 cycles per operator press and returns to 00 only after debounced release.
REQ-020 Digit d: if new_entry flag set, data_out <= d and flag cleared; else data_out <= data_out*10 + d, computed 12-bit wide.
REQ-021 Digit whose result exceeds 255: ignored, data_out unchanged, key_pulse still asserted.
REQ-022 Operator key: data_out unchanged; new_entry flag set so next digit starts a new operand.
REQ-023 * key: data_out <= 0, new_entry flag cleared.
REQ-024 Chords: second key pressed during HELD/DEB_RELEASE ignored; no key accepted until debounced release of the latched key.
REQ-025 Key held indefinitely: single key_pulse, no auto-repeat.

Reset
REQ-026 rst high at a clock edge: state SCAN, col_out 1110, scan/debounce counters 0, signal_out 00, data_out 0, key_pulse 0, new_entry 0.
REQ-027 rst mid-press or mid-release: same values next cycle; a key still held after rst deasserts is re-detected and debounced as a new press.
REQ-028 rst has priority over every other event in the same cycle.

Verification
REQ-029 Press "1","2","3" each held 20 cycles, released 20 -> three key_pulse strobes, data_out 1, 12, 123.
REQ-030 data_out 25, press "6" -> data_out stays 25 (256 > 255), key_pulse asserted once.
REQ-031 Press B held 30 cycles -> signal_out 10 from press acceptance until debounced release, then 00; next "7" -> data_out 7.
REQ-032 Row glitch low 3 cycles (< DEBOUNCE) -> no key_pulse, signal_out 00, scan resumes.
REQ-033 Release bounce: high 3 cycles, low 2, then high -> single key_pulse, signal_out held across bounce.
REQ-034 rst asserted while A held (signal_out 01), data_out 42 -> next cycle signal_out 00, data_out 0, col_out 1110.
